// File: rtl/dino_pkg.sv
// Shared game types and sprite geometry for the dino game pipeline.
package dino_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StOver} game_state_e;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] CACT_TOP = 10'd370;
  localparam logic [9:0] CACT_W   = 10'd12;
  localparam logic [9:0] CACT_H   = 10'd24;
  localparam logic [9:0] DINO_W   = 10'd20;
  localparam logic [9:0] DINO_H   = 10'd22;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear; increments saturate at 9999.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;
  logic        carry;

  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'h9999)) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cactus_ctrl.sv
// Cactus obstacle scroller, dino collision check, IDLE/RUN/OVER game FSM and BCD score.
module cactus_ctrl #(
  parameter logic [21:0] STEP_DIV = 22'd400_000,
  parameter logic [9:0]  SPEED    = 10'd4,
  parameter logic [9:0]  SCREEN_W = dino_pkg::SCREEN_W,
  parameter logic [9:0]  PARK_X   = 10'd700,
  parameter logic [9:0]  CACT_TOP = dino_pkg::CACT_TOP,
  parameter logic [9:0]  CACT_W   = dino_pkg::CACT_W,
  parameter logic [9:0]  CACT_H   = dino_pkg::CACT_H,
  parameter logic [9:0]  DINO_W   = dino_pkg::DINO_W,
  parameter logic [9:0]  DINO_H   = dino_pkg::DINO_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  dino_x,
  input  logic [9:0]  dino_y,
  output logic [9:0]  cactus_x,
  output logic [9:0]  cactus_y,
  output logic [15:0] score_bcd,
  output logic        running,
  output logic        game_over
);

  dino_pkg::game_state_e state_q;

  logic [21:0] cnt_q;
  logic [9:0]  cactus_x_q;
  logic [7:0]  lfsr_q;
  logic        running_q, game_over_q;
  logic        hit, step, respawn, restart;
  logic [9:0]  respawn_x;

  // Overlap test in 11 bits so the box sums cannot wrap.
  assign hit = ({1'b0, dino_x} < ({1'b0, cactus_x_q} + {1'b0, CACT_W})) &&
               ({1'b0, cactus_x_q} < ({1'b0, dino_x} + {1'b0, DINO_W})) &&
               ({1'b0, dino_y} < ({1'b0, CACT_TOP} + {1'b0, CACT_H})) &&
               ({1'b0, CACT_TOP} < ({1'b0, dino_y} + {1'b0, DINO_H}));

  assign step      = (cnt_q == (STEP_DIV - 22'd1));
  assign respawn   = (cactus_x_q < SPEED);
  assign respawn_x = SCREEN_W + {2'b00, lfsr_q[5:0], 2'b00};
  assign restart   = start && (state_q != dino_pkg::StRun);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= dino_pkg::StIdle;
      cnt_q       <= '0;
      cactus_x_q  <= PARK_X;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      unique case (state_q)
        dino_pkg::StIdle, dino_pkg::StOver: begin
          cnt_q <= '0;
          if (start) begin
            state_q     <= dino_pkg::StRun;
            cactus_x_q  <= SCREEN_W;
            running_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        dino_pkg::StRun: begin
          // A collision wins over a scroll step landing on the same cycle.
          if (hit) begin
            state_q     <= dino_pkg::StOver;
            cnt_q       <= '0;
            running_q   <= 1'b0;
            game_over_q <= 1'b1;
          end else if (step) begin
            cnt_q      <= '0;
            cactus_x_q <= respawn ? respawn_x : (cactus_x_q - SPEED);
          end else begin
            cnt_q <= cnt_q + 22'd1;
          end
        end
        default: begin
          state_q <= dino_pkg::StIdle;
        end
      endcase
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart),
    .inc   ((state_q == dino_pkg::StRun) && !hit && step && respawn),
    .count (score_bcd)
  );

  assign cactus_x  = cactus_x_q;
  assign cactus_y  = CACT_TOP;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_cactus_ctrl.sv
// Scoreboard bench for cactus_ctrl: directed scroll/collision/restart plus a fast-step score run.
module tb_cactus_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst2, start, start2;
  logic [9:0]  dino_x, dino_y;
  logic [9:0]  cactus_x, cactus_y, cactus_x2, cactus_y2;
  logic [15:0] score_bcd, score_bcd2;
  logic        running, game_over, running2, game_over2;

  always #5 clk = ~clk;

  cactus_ctrl #(.STEP_DIV(22'd4), .SPEED(10'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dino_x    (dino_x),
    .dino_y    (dino_y),
    .cactus_x  (cactus_x),
    .cactus_y  (cactus_y),
    .score_bcd (score_bcd),
    .running   (running),
    .game_over (game_over)
  );

  // Every step respawns here, so the score counts once per clock.
  cactus_ctrl #(.STEP_DIV(22'd1), .SPEED(10'd1000)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .start     (start2),
    .dino_x    (dino_x),
    .dino_y    (dino_y),
    .cactus_x  (cactus_x2),
    .cactus_y  (cactus_y2),
    .score_bcd (score_bcd2),
    .running   (running2),
    .game_over (game_over2)
  );

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] score_q2[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon2_en = 1'b0;
  logic [15:0] prev2 = 16'h0000;
  logic [7:0]  m_lfsr;
  logic [9:0]  exp_respawn;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [15:0] to_bcd(int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] sig_val(int s);
    case (s)
      0:       return {6'd0, cactus_x};
      1:       return {6'd0, cactus_y};
      2:       return score_bcd;
      3:       return {15'd0, running};
      4:       return {15'd0, game_over};
      5:       return score_bcd2;
      6:       return {15'd0, (cactus_x2 >= 10'd640) && (cactus_x2 <= 10'd892) &&
                              (cactus_x2[1:0] == 2'b00)};
      7:       return {15'd0, running2};
      8:       return {15'd0, game_over2};
      default: return {6'd0, cactus_y2};
    endcase
  endfunction

  task automatic expect_sig(input string name, input int sig, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_idle(input string tag);
    expect_sig({tag, "_cx"}, 0, 16'd700);
    expect_sig({tag, "_score"}, 2, 16'h0000);
    expect_sig({tag, "_running"}, 3, 16'd0);
    expect_sig({tag, "_over"}, 4, 16'd0);
  endtask

  // Monitor: drains the expectation queue just after each falling edge.
  initial begin
    forever begin
      exp_t        e;
      logic [15:0] act;
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = sig_val(e.sig);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got 'h%0h, expected 'h%0h", e.name, act, e.val);
        end
      end
    end
  end

  // Score monitor for the fast instance: every change of score must be the next value.
  initial begin
    forever begin
      logic [15:0] want;
      @(negedge clk);
      #1;
      if (mon2_en && (score_bcd2 !== prev2)) begin
        prev2 = score_bcd2;
        checks++;
        if (score_q2.size() == 0) begin
          errors++;
          $display("FAIL score2_seq: got 'h%0h, expected no further change", score_bcd2);
        end else begin
          want = score_q2.pop_front();
          if (score_bcd2 !== want) begin
            errors++;
            $display("FAIL score2_seq: got 'h%0h, expected 'h%0h", score_bcd2, want);
          end
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    rst2   = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    dino_x = 10'd30;
    dino_y = 10'd260;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    rst2    = 1'b0;
    mon2_en = 1'b1;
    for (int n = 1; n <= 9999; n++) score_q2.push_back(to_bcd(n));
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk);
    expect_idle("idle");
    expect_sig("idle_cy", 1, 16'd370);

    // Start and steady scrolling, dino airborne
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_sig("start_running", 3, 16'd1);
    expect_sig("start_cx", 0, 16'd640);
    expect_sig("start_score", 2, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(negedge clk);
      expect_sig("scroll_hold", 0, 16'(640 - 4 * (k - 1)));
      @(negedge clk);
      expect_sig("scroll_step", 0, 16'(640 - 4 * k));
    end

    // Run down to x=0, then respawn from the LFSR
    repeat (624) @(negedge clk);
    expect_sig("reach_zero_cx", 0, 16'd0);
    expect_sig("reach_zero_score", 2, 16'h0000);
    repeat (3) @(negedge clk);
    exp_respawn = 10'd640 + {2'b00, m_lfsr[5:0], 2'b00};
    @(negedge clk);
    expect_sig("respawn_cx", 0, {6'd0, exp_respawn});
    expect_sig("respawn_score", 2, 16'h0001);

    // Dino on the ground: collision when the cactus reaches x=48
    dino_y = 10'd370;
    for (int i = 0; i < 2000; i++) begin
      if (cactus_x == 10'd48) break;
      @(negedge clk);
    end
    expect_sig("hit_cx", 0, 16'd48);
    expect_sig("hit_still_running", 3, 16'd1);
    expect_sig("hit_not_over_yet", 4, 16'd0);
    @(negedge clk);
    expect_sig("over_flag", 4, 16'd1);
    expect_sig("over_running", 3, 16'd0);
    expect_sig("over_cx", 0, 16'd48);
    repeat (10) @(negedge clk);
    expect_sig("frozen_cx", 0, 16'd48);
    expect_sig("frozen_score", 2, 16'h0001);
    expect_sig("frozen_over", 4, 16'd1);

    // Restart from OVER with a two-cycle start pulse
    dino_y = 10'd260;
    start  = 1'b1;
    @(negedge clk);
    expect_sig("restart_running", 3, 16'd1);
    expect_sig("restart_over", 4, 16'd0);
    expect_sig("restart_score", 2, 16'h0000);
    expect_sig("restart_cx", 0, 16'd640);
    @(negedge clk);
    start = 1'b0;
    expect_sig("long_start_cx", 0, 16'd640);
    repeat (2) @(negedge clk);
    expect_sig("long_start_hold", 0, 16'd640);
    @(negedge clk);
    expect_sig("long_start_step", 0, 16'd636);

    // Reset mid-step wins over a concurrent start
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    expect_idle("rst_mid");
    repeat (8) @(negedge clk);
    expect_idle("rst_settled");

    // Fast instance: wait for saturation, including the 0099 -> 0100 carry on the way
    for (int i = 0; i < 12000; i++) begin
      if (score_bcd2 == 16'h9999) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    expect_sig("score_saturate", 5, 16'h9999);
    expect_sig("fast_cx_range", 6, 16'd1);
    expect_sig("fast_running", 7, 16'd1);
    expect_sig("fast_over", 8, 16'd0);
    expect_sig("fast_cy", 9, 16'd370);
    @(negedge clk);
    #2;
    checks++;
    if (score_q2.size() != 0) begin
      errors++;
      $display("FAIL score2_drained: got %0d pending values, expected 0", score_q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
